// File: rtl/avalon_st_pkt_mux.sv
// Packet-aware round-robin Avalon-ST multiplexer: NUM_CH sources onto one fully registered sink.
// Define AVST_PKT_MUX_CHECK_EN to build the sticky per-channel SOP protocol checker driving err.
module avalon_st_pkt_mux #(
    parameter  int DATA_WIDTH  = 128,
    parameter  int NUM_CH      = 4,
    localparam int EMPTY_WIDTH = $clog2(DATA_WIDTH / 8),
    localparam int CH_WIDTH    = $clog2(NUM_CH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0]  in_data,
    input  logic [NUM_CH-1:0]             in_valid,
    output logic [NUM_CH-1:0]             in_ready,
    input  logic [NUM_CH*EMPTY_WIDTH-1:0] in_empty,
    input  logic [NUM_CH-1:0]             in_sop,
    input  logic [NUM_CH-1:0]             in_eop,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [EMPTY_WIDTH-1:0]        out_empty,
    output logic                          out_sop,
    output logic                          out_eop,
    output logic [CH_WIDTH-1:0]           out_channel,
    output logic [NUM_CH-1:0]             err
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                  state;
    logic [CH_WIDTH-1:0]     rr_ptr;
    logic [CH_WIDTH-1:0]     lock_ch;
    logic [CH_WIDTH-1:0]     grant_ch;
    logic                    grant_found;
    logic [CH_WIDTH-1:0]     sel_ch;
    logic                    sel_valid;
    logic                    load;
    logic                    xfer;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [EMPTY_WIDTH-1:0]  sel_empty;
    logic                    sel_sop;
    logic                    sel_eop;

    // The output stage can accept a new beat whenever it is empty or being drained.
    assign load = !out_valid || out_ready;

    always_comb begin
        int                  idx;
        logic [CH_WIDTH-1:0] cand;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant_found = 1'b0;
        grant_ch    = '0;
        idx         = 0;
        cand        = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            cand = CH_WIDTH'(idx);
            if (!grant_found && in_valid[cand]) begin
                grant_found = 1'b1;
                grant_ch    = cand;
            end
        end
    end

    assign sel_ch    = (state == LOCKED) ? lock_ch : grant_ch;
    assign sel_valid = (state == LOCKED) ? in_valid[lock_ch] : grant_found;
    assign xfer      = sel_valid && load && !rst;

    assign sel_data  = in_data[sel_ch*DATA_WIDTH +: DATA_WIDTH];
    assign sel_empty = in_empty[sel_ch*EMPTY_WIDTH +: EMPTY_WIDTH];
    assign sel_sop   = in_sop[sel_ch];
    assign sel_eop   = in_eop[sel_ch];

    // A locked channel sees ready even while it is idle mid-packet; everyone else waits.
    always_comb begin
        in_ready = '0;
        if (!rst && (state == LOCKED || grant_found))
            in_ready[sel_ch] = load;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            lock_ch     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_empty   <= '0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            out_channel <= '0;
        end else begin
            if (load) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data    <= sel_data;
                    out_empty   <= sel_empty;
                    out_sop     <= sel_sop;
                    out_eop     <= sel_eop;
                    out_channel <= sel_ch;
                end
            end

            if (xfer) begin
                case (state)
                    IDLE: begin
                        rr_ptr <= (grant_ch == CH_WIDTH'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
                        if (!sel_eop) begin
                            lock_ch <= grant_ch;
                            state   <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (sel_eop) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef AVST_PKT_MUX_CHECK_EN
    // Observes accepted beats only; arbitration and forwarding are unaffected.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= '0;
        end else if (xfer) begin
            if (state == IDLE && !sel_sop)  err[sel_ch] <= 1'b1;
            if (state == LOCKED && sel_sop) err[sel_ch] <= 1'b1;
        end
    end
`else
    assign err = '0;
`endif

endmodule

// File: tb/tb_avalon_st_pkt_mux.sv
// Self-checking bench for avalon_st_pkt_mux: vector table, directed corner sequences and
// a randomized run against a transaction-level arbitration model.
module tb_avalon_st_pkt_mux;

    localparam int DW = 128;
    localparam int N  = 4;
    localparam int EW = $clog2(DW / 8);
    localparam int CW = $clog2(N);

`ifdef AVST_PKT_MUX_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [N*DW-1:0]   in_data;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [N*EW-1:0]   in_empty;
    logic [N-1:0]      in_sop;
    logic [N-1:0]      in_eop;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic [EW-1:0]     out_empty;
    logic              out_sop;
    logic              out_eop;
    logic [CW-1:0]     out_channel;
    logic [N-1:0]      err;

    int checks = 0;
    int errors = 0;

    avalon_st_pkt_mux #(.DATA_WIDTH(DW), .NUM_CH(N)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_empty(in_empty), .in_sop(in_sop), .in_eop(in_eop),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_empty(out_empty), .out_sop(out_sop), .out_eop(out_eop),
        .out_channel(out_channel), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] dat(input int step, input int ch);
        return DW'(step * 4096 + ch * 16 + 7);
    endfunction

    function automatic logic [EW-1:0] emp(input int step, input int ch);
        return EW'((step + 3 * ch) % 16);
    endfunction

    task automatic set_ch(input int ch, input logic v, input logic s, input logic e,
                          input logic [DW-1:0] d, input logic [EW-1:0] em);
        in_valid[ch]         = v;
        in_sop[ch]           = s;
        in_eop[ch]           = e;
        in_data[ch*DW +: DW] = d;
        in_empty[ch*EW +: EW] = em;
    endtask

    task automatic idle_inputs();
        in_valid = '0;
        in_sop   = '0;
        in_eop   = '0;
    endtask

    task automatic check_beat(input string name, input int ch, input logic [DW-1:0] d,
                              input logic s, input logic e);
        check({name, " valid"}, out_valid, 1'b1);
        check({name, " beat"}, {out_channel, out_sop, out_eop, out_data},
              {CW'(ch), s, e, d});
    endtask

    // Entered and left on a falling edge; inputs are held active to prove ready is masked.
    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = '1;
        in_sop    = '1;
        in_eop    = '0;
        out_ready = 1'b1;
        #1 check("rst in_ready", in_ready, '0);
        @(negedge clk);
        @(negedge clk);
        check("rst out", {out_valid, out_sop, out_eop, out_empty, out_channel, err},
              '0);
        check("rst out_data", out_data, '0);
        rst = 1'b0;
        idle_inputs();
    endtask

    typedef struct {
        logic [N-1:0] v;
        logic [N-1:0] sop;
        logic [N-1:0] eop;
        logic         ordy;
        logic [N-1:0] rdy;
        logic         ov;
        int           stp;
        int           ch;
        logic         s;
        logic         e;
    } vec_t;

    vec_t vec [14];

    // Random-run state: per-channel packet sources and the reference model.
    int            bt [N];
    int            plen [N];
    int            pkt [N];
    int            owner;
    int            ptr;
    int            cand;
    logic          mv;
    logic [135:0]  mbeat;
    logic          load_m;
    logic [N-1:0]  exp_rdy;

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_empty  = '0;
        out_ready = 1'b1;
        idle_inputs();

        // Fields: valid, sop, eop, out_ready | in_ready, out_valid, src step, src ch, sop, eop
        vec[0]  = '{4'b1001, 4'b1001, 4'b1001, 1'b1, 4'b0001, 1'b1, 0,  0, 1'b1, 1'b1};
        vec[1]  = '{4'b1001, 4'b1001, 4'b1001, 1'b1, 4'b1000, 1'b1, 1,  3, 1'b1, 1'b1};
        vec[2]  = '{4'b1001, 4'b1001, 4'b1001, 1'b1, 4'b0001, 1'b1, 2,  0, 1'b1, 1'b1};
        vec[3]  = '{4'b1001, 4'b1001, 4'b1001, 1'b1, 4'b1000, 1'b1, 3,  3, 1'b1, 1'b1};
        vec[4]  = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 0,  0, 1'b0, 1'b0};
        vec[5]  = '{4'b0110, 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 5,  1, 1'b1, 1'b0};
        vec[6]  = '{4'b0110, 4'b0100, 4'b0000, 1'b1, 4'b0010, 1'b1, 6,  1, 1'b0, 1'b0};
        vec[7]  = '{4'b0100, 4'b0100, 4'b0000, 1'b1, 4'b0010, 1'b0, 0,  0, 1'b0, 1'b0};
        vec[8]  = '{4'b0110, 4'b0100, 4'b0010, 1'b0, 4'b0010, 1'b1, 8,  1, 1'b0, 1'b1};
        vec[9]  = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b1, 8,  1, 1'b0, 1'b1};
        vec[10] = '{4'b0100, 4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 10, 2, 1'b1, 1'b0};
        vec[11] = '{4'b0101, 4'b0001, 4'b0101, 1'b1, 4'b0100, 1'b1, 11, 2, 1'b0, 1'b1};
        vec[12] = '{4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 12, 0, 1'b1, 1'b1};
        vec[13] = '{4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 0,  0, 1'b0, 1'b0};

        @(negedge clk);
        do_reset();

        // Table: alternating single beats, lock with stall, backpressure, no-bubble switch.
        for (int i = 0; i < 14; i++) begin
            for (int c = 0; c < N; c++)
                set_ch(c, vec[i].v[c], vec[i].sop[c], vec[i].eop[c], dat(i, c), emp(i, c));
            out_ready = vec[i].ordy;
            #1 check($sformatf("tbl%0d in_ready", i), in_ready, vec[i].rdy);
            @(negedge clk);
            check($sformatf("tbl%0d out_valid", i), out_valid, vec[i].ov);
            if (vec[i].ov)
                check($sformatf("tbl%0d beat", i),
                      {out_channel, out_sop, out_eop, out_empty, out_data},
                      {CW'(vec[i].ch), vec[i].s, vec[i].e, emp(vec[i].stp, vec[i].ch),
                       dat(vec[i].stp, vec[i].ch)});
        end
        check("tbl err", err, '0);

        // Single channel 3-beat packet with empty=5 on EOP.
        do_reset();
        for (int b = 0; b < 3; b++) begin
            set_ch(2, 1'b1, b == 0, b == 2, dat(100 + b, 2), (b == 2) ? EW'(5) : EW'(0));
            #1 check("single in_ready", in_ready, 4'b0100);
            @(negedge clk);
            check_beat($sformatf("single b%0d", b), 2, dat(100 + b, 2), b == 0, b == 2);
            if (b == 2) check("single empty", out_empty, EW'(5));
        end
        idle_inputs();
        @(negedge clk);
        check("single drain", out_valid, 1'b0);

        // Round robin: four 2-beat packets valid together, expect 8 back-to-back beats.
        do_reset();
        for (int c = 0; c < N; c++) bt[c] = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (bt[c] < 2) set_ch(c, 1'b1, bt[c] == 0, bt[c] == 1, dat(200 + bt[c], c), '0);
                else           set_ch(c, 1'b0, 1'b0, 1'b0, '0, '0);
            end
            #1;
            for (int c = 0; c < N; c++)
                if (in_ready[c] && in_valid[c]) bt[c]++;
            @(negedge clk);
            if (cyc < 8)
                check_beat($sformatf("rr c%0d", cyc), cyc / 2, dat(200 + cyc % 2, cyc / 2),
                           cyc % 2 == 0, cyc % 2 == 1);
            else
                check($sformatf("rr c%0d valid", cyc), out_valid, 1'b0);
        end

        // Lock: ch1 stalls mid-packet for 3 cycles while ch0 waits.
        do_reset();
        set_ch(1, 1'b1, 1'b1, 1'b0, dat(300, 1), '0);
        @(negedge clk);
        check_beat("lock sop", 1, dat(300, 1), 1'b1, 1'b0);
        set_ch(1, 1'b0, 1'b0, 1'b0, dat(301, 1), '0);
        set_ch(0, 1'b1, 1'b1, 1'b1, dat(310, 0), '0);
        for (int s = 0; s < 3; s++) begin
            #1 check($sformatf("lock s%0d ready0", s), in_ready[0], 1'b0);
            @(negedge clk);
            check($sformatf("lock s%0d valid", s), out_valid, 1'b0);
        end
        set_ch(1, 1'b1, 1'b0, 1'b1, dat(301, 1), EW'(2));
        #1 check("lock resume ready", in_ready, 4'b0010);
        @(negedge clk);
        check_beat("lock eop", 1, dat(301, 1), 1'b0, 1'b1);
        set_ch(1, 1'b0, 1'b0, 1'b0, '0, '0);
        #1 check("lock next ready", in_ready, 4'b0001);
        @(negedge clk);
        check_beat("lock next", 0, dat(310, 0), 1'b1, 1'b1);
        idle_inputs();
        @(negedge clk);

        // Backpressure: out_ready low for 4 cycles mid-packet on ch3.
        do_reset();
        set_ch(3, 1'b1, 1'b1, 1'b0, dat(400, 3), '0);
        @(negedge clk);
        check_beat("bp b0", 3, dat(400, 3), 1'b1, 1'b0);
        set_ch(3, 1'b1, 1'b0, 1'b0, dat(401, 3), '0);
        out_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
            #1 check($sformatf("bp s%0d in_ready", s), in_ready, '0);
            @(negedge clk);
            check_beat($sformatf("bp s%0d hold", s), 3, dat(400, 3), 1'b1, 1'b0);
        end
        out_ready = 1'b1;
        #1 check("bp release ready", in_ready, 4'b1000);
        @(negedge clk);
        check_beat("bp b1", 3, dat(401, 3), 1'b0, 1'b0);
        set_ch(3, 1'b1, 1'b0, 1'b1, dat(402, 3), '0);
        @(negedge clk);
        check_beat("bp b2", 3, dat(402, 3), 1'b0, 1'b1);
        idle_inputs();
        @(negedge clk);
        check("bp no dup", out_valid, 1'b0);

        // Checker: repeated SOP while locked, then a headless beat in IDLE.
        do_reset();
        set_ch(1, 1'b1, 1'b1, 1'b0, dat(500, 1), '0);
        @(negedge clk);
        check("chk clean", err, '0);
        set_ch(1, 1'b1, 1'b1, 1'b0, dat(501, 1), '0);
        @(negedge clk);
        check_beat("chk fwd", 1, dat(501, 1), 1'b1, 1'b0);
        check("chk err1", err, CHK ? 4'b0010 : 4'b0000);
        set_ch(1, 1'b1, 1'b0, 1'b1, dat(502, 1), '0);
        @(negedge clk);
        check("chk err1 sticky", err, CHK ? 4'b0010 : 4'b0000);
        set_ch(1, 1'b0, 1'b0, 1'b0, '0, '0);
        set_ch(2, 1'b1, 1'b0, 1'b1, dat(503, 2), '0);
        @(negedge clk);
        check_beat("chk idle fwd", 2, dat(503, 2), 1'b0, 1'b1);
        check("chk err2", err, CHK ? 4'b0110 : 4'b0000);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        check("chk err hold", err, CHK ? 4'b0110 : 4'b0000);

        // Reset mid-packet drops the lock and the round-robin pointer.
        set_ch(0, 1'b1, 1'b1, 1'b0, dat(600, 0), '0);
        @(negedge clk);
        do_reset();
        set_ch(3, 1'b1, 1'b1, 1'b1, dat(601, 3), '0);
        #1 check("postrst ready", in_ready, 4'b1000);
        @(negedge clk);
        check_beat("postrst beat", 3, dat(601, 3), 1'b1, 1'b1);
        idle_inputs();
        @(negedge clk);

        // Randomized traffic against the reference model.
        do_reset();
        owner = -1;
        ptr   = 0;
        mv    = 1'b0;
        mbeat = '0;
        for (int c = 0; c < N; c++) begin
            bt[c]   = 0;
            pkt[c]  = 0;
            plen[c] = $urandom_range(1, 4);
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            check($sformatf("rnd%0d valid", cyc), out_valid, mv);
            if (mv)
                check($sformatf("rnd%0d beat", cyc),
                      {out_channel, out_sop, out_eop, out_empty, out_data}, mbeat);

            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < N; c++)
                set_ch(c, $urandom_range(0, 3) != 0, bt[c] == 0, bt[c] == plen[c] - 1,
                       dat(pkt[c] * 8 + bt[c], c), emp(pkt[c] + bt[c], c));
            #1;

            load_m = !mv || out_ready;
            cand   = -1;
            if (owner >= 0) begin
                if (in_valid[owner]) cand = owner;
            end else begin
                for (int k = 0; k < N; k++)
                    if (cand < 0 && in_valid[(ptr + k) % N]) cand = (ptr + k) % N;
            end
            exp_rdy = '0;
            if (owner >= 0)     exp_rdy[owner] = load_m;
            else if (cand >= 0) exp_rdy[cand]  = load_m;
            check($sformatf("rnd%0d in_ready", cyc), in_ready, exp_rdy);

            if (load_m) begin
                mv = (cand >= 0);
                if (cand >= 0) begin
                    mbeat = {CW'(cand), in_sop[cand], in_eop[cand],
                             in_empty[cand*EW +: EW], in_data[cand*DW +: DW]};
                    if (owner < 0) begin
                        ptr = (cand + 1) % N;
                        if (!in_eop[cand]) owner = cand;
                    end else if (in_eop[cand]) begin
                        owner = -1;
                    end
                    bt[cand]++;
                    if (bt[cand] == plen[cand]) begin
                        bt[cand]   = 0;
                        pkt[cand]++;
                        plen[cand] = $urandom_range(1, 4);
                    end
                end
            end
            @(negedge clk);
        end
        check("rnd err", err, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
